regfile_wr_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: requester A (ALU/jump result) and requester B (DMEM load return).
- Grants one write per cycle using round-robin arbitration, with a registered one-hot write-enable and write-data output driving the per-register enables.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards against in-flight loads and ALU results.

---
 rtl/regfile_wr_arbiter_pkg.sv | 13 +
 rtl/regfile_wr_arbiter_decoder.sv | 17 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 38 +++
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared requester indices and round-robin pointer encoding for the
// register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wr_arbiter_decoder.sv
// N-to-2^N one-hot decoder with a global enable.
module decoder_nto2_n #(
  parameter int N = 5
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [(2**N)-1:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < (2**N); gi++) begin : g_dec
      assign out[gi] = en && (sel == N'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, registered pointer
// that moves to the losing side after every grant.
module rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       async_reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    // No grants while reset is held so nothing can be accepted and then lost.
    if (!async_reset) begin
      gnt[REQ_A] = req[REQ_A] && (!req[REQ_B] || (ptr_q == PTR_A));
      gnt[REQ_B] = req[REQ_B] && (!req[REQ_A] || (ptr_q == PTR_B));
    end
    if (gnt[REQ_A]) begin
      ptr_d = PTR_B;
    end else if (gnt[REQ_B]) begin
      ptr_d = PTR_A;
    end
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the ALU (A) and load return (B),
// producing a registered one-hot write enable plus a pending-write scoreboard.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int bits            = 32,
  parameter int no_of_registers = 32,
  localparam int AW             = $clog2(no_of_registers)
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       a_valid,
  input  logic [AW-1:0]              a_rd,
  input  logic [bits-1:0]            a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [AW-1:0]              b_rd,
  input  logic [bits-1:0]            b_data,
  output logic                       b_ready,
  input  logic                       rsv_valid,
  input  logic [AW-1:0]              rsv_rd,
  output logic [no_of_registers-1:0] wr_en,
  output logic [bits-1:0]            wr_data,
  output logic [no_of_registers-1:0] pending
);

  logic [1:0]                 gnt;
  logic                       any_gnt;
  logic [AW-1:0]              sel_rd;
  logic [bits-1:0]            sel_data;
  logic [(2**AW)-1:0]         gnt_onehot;
  logic [(2**AW)-1:0]         rsv_onehot;

  logic [no_of_registers-1:0] wr_en_q;
  logic [no_of_registers-1:0] wr_en_d;
  logic [bits-1:0]            wr_data_q;
  logic [bits-1:0]            wr_data_d;
  logic [no_of_registers-1:0] pending_q;
  logic [no_of_registers-1:0] pending_d;

  rr_arb2 u_arb (
    .clk         (clk),
    .async_reset (async_reset),
    .req         ({b_valid, a_valid}),
    .gnt         (gnt)
  );

  assign a_ready  = gnt[REQ_A];
  assign b_ready  = gnt[REQ_B];
  assign any_gnt  = |gnt;
  assign sel_rd   = gnt[REQ_B] ? b_rd   : a_rd;
  assign sel_data = gnt[REQ_B] ? b_data : a_data;

  // x0 writes still handshake, but neither decode ever touches register 0.
  decoder_nto2_n #(.N(AW)) u_gnt_dec (
    .sel (sel_rd),
    .en  (any_gnt && (sel_rd != '0)),
    .out (gnt_onehot)
  );

  decoder_nto2_n #(.N(AW)) u_rsv_dec (
    .sel (rsv_rd),
    .en  (rsv_valid && (rsv_rd != '0)),
    .out (rsv_onehot)
  );

  always_comb begin
    wr_en_d   = gnt_onehot[no_of_registers-1:0];
    wr_data_d = any_gnt ? sel_data : wr_data_q;
    // Set is applied after clear: a same-cycle reservation belongs to a newer instruction.
    pending_d = (pending_q & ~gnt_onehot[no_of_registers-1:0])
              | rsv_onehot[no_of_registers-1:0];
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

endmodule
